// File: rtl/ram512_arbiter.sv
// rtl/ram512_arbiter.sv - round-robin two-port front end and clear sequencer for RAM512
module ram512_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [8:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [8:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_rdata,
  input  logic        clear_start,
  output logic        busy,
  output logic        clear_done,
  output logic [15:0] mem_in,
  output logic        mem_load,
  output logic [8:0]  mem_address,
  input  logic [15:0] mem_out
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state;
  state_t      state_nx;
  logic        ptr;
  logic [8:0]  cnt;
  logic        grant0;
  logic        grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (clear_start) state_nx = CLEAR;
      CLEAR:   if (cnt == 9'd511) state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    mem_in      = 16'h0000;
    mem_load    = 1'b0;
    mem_address = 9'd0;
    if (rst_n) begin
      case (state)
        ARB: begin
          grant0 = req0_valid & (~req1_valid | ~ptr);
          grant1 = req1_valid & (~req0_valid | ptr);
          if (grant0) begin
            mem_in      = req0_wdata;
            mem_load    = req0_we;
            mem_address = req0_addr;
          end else if (grant1) begin
            mem_in      = req1_wdata;
            mem_load    = req1_we;
            mem_address = req1_addr;
          end
        end
        CLEAR: begin
          mem_load    = 1'b1;
          mem_address = cnt;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      cnt        <= 9'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= 16'h0000;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      if (grant0)      ptr <= 1'b1;
      else if (grant1) ptr <= 1'b0;
      cnt        <= (state == CLEAR) ? cnt + 9'd1 : 9'd0;
      rsp0_valid <= grant0 & ~req0_we;
      rsp1_valid <= grant1 & ~req1_we;
      if ((grant0 & ~req0_we) | (grant1 & ~req1_we)) rsp_rdata <= mem_out;
      busy       <= (state_nx == CLEAR);
      clear_done <= (state == CLEAR) && (state_nx == ARB);
    end
  end

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb/tb_ram512_arbiter.sv - directed bench for ram512_arbiter with a behavioural RAM512
module tb_ram512_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [8:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp_rdata;
  logic        clear_start, busy, clear_done;
  logic [15:0] mem_in, mem_out;
  logic        mem_load;
  logic [8:0]  mem_address;

  logic [15:0] ram [512];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_out = ram[mem_address];
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;

  ram512_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .mem_in(mem_in), .mem_load(mem_load), .mem_address(mem_address),
    .mem_out(mem_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [8:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int p, input logic [8:0] a, input logic [15:0] d);
    drive(p, 1'b1, a, d);
    #1;
    chk("write_ready", (p == 0) ? req0_ready : req1_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic do_read(input int p, input logic [8:0] a, input logic [15:0] exp);
    drive(p, 1'b0, a, 16'h0);
    #1;
    chk("read_ready", (p == 0) ? req0_ready : req1_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("read_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (p == 0) ? 32'd1 : 32'd2);
    chk("read_rdata", rsp_rdata, exp);
  endtask

  initial begin
    int nb, nd;
    logic bad;
    rst_n = 1'b0; clear_start = 1'b0;
    req0_we = 1'b0; req0_addr = 9'd5; req0_wdata = 16'h1234;
    req1_we = 1'b1; req1_addr = 9'd6; req1_wdata = 16'h5678;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    chk("rst_readys", {req1_ready, req0_ready}, 0);
    chk("rst_mem_load", mem_load, 0);
    chk("rst_regs", {rsp0_valid, rsp1_valid, busy, clear_done}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Preload contention targets: ptr ends at 0 after port 1's grant.
    do_write(0, 9'd3, 16'h0003);
    do_write(1, 9'd4, 16'h0004);
    drive(0, 1'b0, 9'd3, 16'h0);
    drive(1, 1'b0, 9'd4, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("cont_rsp", {rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_data", rsp_rdata, (i % 2 == 0) ? 32'h0003 : 32'h0004);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rsp_idle", {rsp1_valid, rsp0_valid}, 0);
    chk("rdata_hold", rsp_rdata, 16'h0004);

    do_write(0, 9'h1A5, 16'hBEEF);
    do_read(0, 9'h1A5, 16'hBEEF);

    // ptr = 1 after port 0 grant: simultaneous writes, port 1 goes first.
    drive(0, 1'b1, 9'd7, 16'h1111);
    drive(1, 1'b1, 9'd7, 16'h2222);
    #1;
    chk("wp_first", {req1_ready, req0_ready}, 2);
    chk("wp_mem_in", mem_in, 16'h2222);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("wp_second", {req1_ready, req0_ready}, 1);
    tick();
    req0_valid = 1'b0;
    chk("wp_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    do_read(0, 9'd7, 16'h1111);

    do_write(0, 9'd0, 16'h00AA);
    do_write(1, 9'd255, 16'h55AA);
    do_write(0, 9'd511, 16'hFFFF);
    do_write(1, 9'd9, 16'h0909);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    nb = 0; nd = 0; bad = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (clear_done) nd++;
      if (!busy) break;
      nb++;
      if (req1_ready || req0_ready || !mem_load) bad = 1'b1;
      if (nb == 100) drive(1, 1'b0, 9'd9, 16'h0);
      tick();
    end
    chk("clear_busy_cycles", nb, 512);
    chk("clear_done_at_exit", clear_done, 1);
    chk("clear_no_grant", bad, 0);
    #1;
    chk("post_clear_grant", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    if (clear_done) nd++;
    chk("clear_done_count", nd, 1);
    chk("held_read_rsp", {rsp1_valid, rsp0_valid}, 2);
    chk("held_read_data", rsp_rdata, 0);
    do_read(0, 9'd0, 16'h0000);
    do_read(0, 9'd255, 16'h0000);
    do_read(0, 9'd511, 16'h0000);

    // Reset mid-clear with ptr = 1 beforehand.
    do_write(1, 9'd400, 16'h4444);
    do_write(0, 9'd1, 16'h0101);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("mid_clear_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_load", mem_load, 0);
    #2;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (clear_done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    drive(0, 1'b0, 9'd400, 16'h0);
    drive(1, 1'b0, 9'd1, 16'h0);
    #1;
    chk("abort_ptr0", {req1_ready, req0_ready}, 1);
    tick();
    req0_valid = 1'b0;
    chk("addr400_kept", rsp_rdata, 16'h4444);
    #1;
    chk("abort_port1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("addr1_cleared", rsp_rdata, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
